// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: encodings shared by the pipeline control blocks
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        PCSEL_SEQ = 2'd0,
        PCSEL_ID  = 2'd1,
        PCSEL_JR  = 2'd2,
        PCSEL_EXC = 2'd3
    } pc_sel_e;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_MD_WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: flags an ID instruction that needs the result of a load still in EX
module load_use_detect (
    input  logic       ex_memread_i,
    input  logic [4:0] ex_rt_i,
    input  logic [4:0] id_rs_i,
    input  logic [4:0] id_rt_i,
    input  logic       id_uses_rt_i,
    output logic       hazard_o
);

    // r0 is hardwired to zero, so a load into it never creates a dependency
    assign hazard_o = ex_memread_i && (ex_rt_i != 5'd0) &&
                      ((ex_rt_i == id_rs_i) || (id_uses_rt_i && (ex_rt_i == id_rt_i)));

endmodule

// File: rtl/hazard_sequencer.sv
// hazard_sequencer: stall, flush and next-PC control for the 5-stage pipeline
module hazard_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    input  logic       idex_memread,
    input  logic [4:0] idex_rt,
    input  logic       id_redirect,
    input  logic       ex_jr,
    input  logic       md_start,
    input  logic       irq,
    input  logic       eret,
    output logic       pc_write,
    output logic       ifid_write,
    output logic       ifid_flush,
    output logic       idex_flush,
    output logic       ex_hold,
    output logic [1:0] pc_sel,
    output logic       epc_capture,
    output logic       busy
);

    localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MD_LAT - 2);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             int_mask_q, int_mask_d;
    logic             load_use;
    logic             take_irq;
    pc_sel_e          sel;

    load_use_detect u_load_use (
        .ex_memread_i (idex_memread),
        .ex_rt_i      (idex_rt),
        .id_rs_i      (id_rs),
        .id_rt_i      (id_rt),
        .id_uses_rt_i (id_uses_rt),
        .hazard_o     (load_use)
    );

    // an eret in the same cycle defers the interrupt so it is taken once, after the mask clears
    assign take_irq = irq && !int_mask_q && !eret;
    assign pc_sel   = sel;
    assign busy     = !reset && (state_q == ST_MD_WAIT);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        int_mask_d  = eret ? 1'b0 : int_mask_q;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        ex_hold     = 1'b0;
        sel         = PCSEL_SEQ;
        epc_capture = 1'b0;
        if (reset) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
        end else if (state_q == ST_MD_WAIT) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            ex_hold    = 1'b1;
            state_d    = (cnt_q == '0) ? ST_RUN : ST_MD_WAIT;
            cnt_d      = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
        end else if (take_irq) begin
            epc_capture = 1'b1;
            sel         = PCSEL_EXC;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            int_mask_d  = 1'b1;
        end else if (ex_jr) begin
            sel        = PCSEL_JR;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (md_start) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            ex_hold    = 1'b1;
            cnt_d      = MD_LOAD;
            state_d    = ST_MD_WAIT;
        end else if (load_use) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
        end else if (id_redirect) begin
            sel        = PCSEL_ID;
            ifid_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_RUN;
            cnt_q      <= '0;
            int_mask_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            int_mask_q <= int_mask_d;
        end
    end

endmodule

// File: tb/tb_hazard_sequencer.sv
// tb_hazard_sequencer: scenario checks of hazard_sequencer against a queue of expected output vectors
module tb_hazard_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs, id_rt, idex_rt;
    logic       id_uses_rt, idex_memread, id_redirect, ex_jr, md_start, irq, eret;
    logic       pc_write, ifid_write, ifid_flush, idex_flush, ex_hold, epc_capture, busy;
    logic [1:0] pc_sel;

    int checks   = 0;
    int failures = 0;

    // {pc_write, ifid_write, ifid_flush, idex_flush, ex_hold, pc_sel, epc_capture, busy}
    localparam logic [8:0] RST  = 9'b0_0_0_0_0_00_0_0;
    localparam logic [8:0] NORM = 9'b1_1_0_0_0_00_0_0;
    localparam logic [8:0] LU   = 9'b0_0_0_1_0_00_0_0;
    localparam logic [8:0] MD0  = 9'b0_0_0_0_1_00_0_0;
    localparam logic [8:0] MDW  = 9'b0_0_0_0_1_00_0_1;
    localparam logic [8:0] IRQ  = 9'b1_1_1_1_0_11_1_0;
    localparam logic [8:0] JR   = 9'b1_1_1_1_0_10_0_0;
    localparam logic [8:0] IDR  = 9'b1_1_1_0_0_01_0_0;

    logic [8:0] exp_q[$];
    string      name_q[$];

    always #5 clk = ~clk;

    hazard_sequencer #(.MD_LAT(4), .CNT_W(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rt   (id_uses_rt),
        .idex_memread (idex_memread),
        .idex_rt      (idex_rt),
        .id_redirect  (id_redirect),
        .ex_jr        (ex_jr),
        .md_start     (md_start),
        .irq          (irq),
        .eret         (eret),
        .pc_write     (pc_write),
        .ifid_write   (ifid_write),
        .ifid_flush   (ifid_flush),
        .idex_flush   (idex_flush),
        .ex_hold      (ex_hold),
        .pc_sel       (pc_sel),
        .epc_capture  (epc_capture),
        .busy         (busy)
    );

    task automatic idle_inputs();
        id_rs = 5'd0; id_rt = 5'd0; idex_rt = 5'd0; id_uses_rt = 1'b0;
        idex_memread = 1'b0; id_redirect = 1'b0; ex_jr = 1'b0;
        md_start = 1'b0; irq = 1'b0; eret = 1'b0;
    endtask

    // inputs are already set; queue the expectation, compare mid-cycle, then advance to just past the next edge
    task automatic cycle(input string nm, input logic [8:0] exp);
        logic [8:0] got, e;
        string      n;
        exp_q.push_back(exp);
        name_q.push_back(nm);
        @(negedge clk);
        got = {pc_write, ifid_write, ifid_flush, idex_flush, ex_hold, pc_sel, epc_capture, busy};
        e = exp_q.pop_front();
        n = name_q.pop_front();
        checks++;
        if (got !== e) begin
            failures++;
            $display("FAIL %s: got %b expected %b (pcw,ifw,iff,idf,hold,sel,epc,busy)", n, got, e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        irq = 1'b1;
        md_start = 1'b1;
        reset = 1'b1;
        #2;
        cycle("reset_outputs", RST);
        cycle("reset_outputs_hold", RST);
        idle_inputs();
        reset = 1'b0;
        cycle("after_reset_idle", NORM);
    endtask

    task automatic test_load_use();
        idex_memread = 1'b1; idex_rt = 5'd5; id_rs = 5'd5;
        cycle("load_use_rs", LU);
        idle_inputs();
        cycle("load_use_one_cycle", NORM);
        idex_memread = 1'b1; idex_rt = 5'd0; id_rs = 5'd0;
        cycle("load_use_r0", NORM);
        idex_memread = 1'b1; idex_rt = 5'd7; id_rs = 5'd3; id_rt = 5'd7; id_uses_rt = 1'b1;
        cycle("load_use_rt", LU);
        id_uses_rt = 1'b0;
        cycle("load_use_rt_unused", NORM);
        idex_memread = 1'b0; id_uses_rt = 1'b1;
        cycle("no_load_no_stall", NORM);
        idle_inputs();
    endtask

    task automatic test_priority();
        ex_jr = 1'b1; id_redirect = 1'b1;
        cycle("jr_over_redirect", JR);
        ex_jr = 1'b0; idex_memread = 1'b1; idex_rt = 5'd9; id_rs = 5'd9;
        cycle("load_use_over_redirect", LU);
        idex_memread = 1'b0;
        cycle("redirect_reevaluated", IDR);
        idle_inputs();
        cycle("idle", NORM);
    endtask

    task automatic test_muldiv();
        md_start = 1'b1;
        cycle("md_start", MD0);
        md_start = 1'b0; irq = 1'b1;
        ex_jr = 1'b1;
        cycle("md_wait1", MDW);
        cycle("md_wait2", MDW);
        cycle("md_wait3", MDW);
        ex_jr = 1'b0;
        cycle("md_deferred_irq", IRQ);
        cycle("irq_masked_after_md", NORM);
        irq = 1'b0; eret = 1'b1;
        cycle("eret_clear", NORM);
        eret = 1'b0;
    endtask

    task automatic test_interrupt();
        irq = 1'b1;
        cycle("irq_taken", IRQ);
        cycle("irq_masked1", NORM);
        cycle("irq_masked2", NORM);
        eret = 1'b1;
        cycle("irq_eret_same_cycle", NORM);
        eret = 1'b0;
        cycle("irq_retaken", IRQ);
        cycle("irq_masked3", NORM);
        irq = 1'b0; eret = 1'b1;
        cycle("eret_unmask", NORM);
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        md_start = 1'b1;
        cycle("b2b_start1", MD0);
        cycle("b2b_wait1a", MDW);
        cycle("b2b_wait1b", MDW);
        cycle("b2b_wait1c", MDW);
        cycle("b2b_start2", MD0);
        md_start = 1'b0;
        cycle("b2b_wait2a", MDW);
        cycle("b2b_wait2b", MDW);
        cycle("b2b_wait2c", MDW);
        cycle("b2b_resume", NORM);
    endtask

    task automatic test_reset_mid_md();
        md_start = 1'b1;
        cycle("rmd_start", MD0);
        md_start = 1'b0;
        cycle("rmd_wait_cnt2", MDW);
        reset = 1'b1;
        cycle("rmd_reset_cnt1", RST);
        reset = 1'b0;
        cycle("rmd_released", NORM);
        cycle("rmd_still_run", NORM);
    endtask

    initial begin
        idle_inputs();
        reset = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_load_use();
        test_priority();
        test_muldiv();
        test_interrupt();
        test_back_to_back();
        test_reset_mid_md();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
